riscv_v_mem_wb_pipe: RTL and testbench
======================================

# riscv_v_mem_wb_pipe

Two-stage post-execute pipeline for the vector unit. It registers the vector execute result into the MEM and WB stages and drives the per-byte register-file write port. It feeds the MEM/WB bypass inputs back to execute and hands vector-to-integer (v2i) results to the scalar core over a valid/ready handshake, back-pressuring execute while that hand-off is pending.

## Interface
Parameters:
- DATA_WIDTH, 128, vector data width (riscv_v_pkg RISCV_V_DATA_WIDTH)
- NUM_BYTES, DATA_WIDTH/8, byte-enable width
- INT_WIDTH, 32, scalar result width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- valid_exe  in  1  execute stage holds a valid op
- ready_exe  out  1  MEM can accept this cycle
- alu_result_exe  in  DATA_WIDTH+NUM_BYTES  {data[DATA_WIDTH+NUM_BYTES-1:NUM_BYTES], byte_en[NUM_BYTES-1:0]}
- rf_wr_addr_exe  in  5  destination vreg
- is_v2i_exe  in  1  op returns a scalar result
- int_data_result_exe  in  INT_WIDTH  scalar result
- flush  in  1  kill the op in MEM and the op being captured from EXE
- rf_wr_en_mem / rf_wr_addr_mem / rf_wr_data_mem  out  NUM_BYTES / 5 / DATA_WIDTH  MEM-stage bypass
- rf_wr_en_wb / rf_wr_addr_wb / rf_wr_data_wb  out  NUM_BYTES / 5 / DATA_WIDTH  WB stage; this is also the RF write port
- int_result_valid  out  1  scalar result offered
- int_result_data  out  INT_WIDTH
- int_result_ready  in  1  scalar core accepts
- perf_retired_cnt  out  32  ops retired from WB
- perf_stall_cnt  out  32  MEM stall cycles

## Operation
- The MEM register captures the EXE fields when valid_exe & ready_exe & ~flush. If ready_exe & ~valid_exe, or on flush, MEM becomes a bubble (mem_valid=0).
- At capture, byte_en is forced to 0 for v2i ops. Those ops write no vector register.
- stall = mem_valid & mem_is_v2i & ~int_result_ready. ready_exe = ~stall.
- int_result_valid = mem_valid & mem_is_v2i. int_result_data = the registered scalar result.
- While stalled:
  - MEM holds all fields.
  - WB captures a bubble.
  - Outputs are stable until ready or flush.
- WB captures MEM when MEM is valid and not stalled. Otherwise WB is a bubble. WB is never flushed, because its op is older than the flush point.
- rf_wr_en_mem = mem_valid ? mem_byte_en : 0. rf_wr_en_wb = wb_valid ? wb_byte_en : 0.
- Addresses and data are registered as captured. Their values are don't-care when the matching enable is 0.
- A v2i op still flows to WB after its handshake completes (all enables 0) and counts as retired.

## Timing
- Reset (rst low, asynchronous): mem_valid=0, wb_valid=0, every output 0, ready_exe=1, counters 0.
- Latency: EXE capture to MEM bypass is 1 cycle. EXE to RF write (WB) is 2 cycles.
- Handshake: the transfer occurs on a cycle with int_result_valid & int_result_ready. That edge advances MEM.
- Flush with a pending int_result_valid: flush wins, and valid deasserts after the edge. Withdrawal without a handshake is legal on this interface.
- Flush while valid_exe=1: the EXE op is not captured, and MEM becomes a bubble.
- Back-to-back v2i ops, ready held at 1: one op per cycle, no bubbles.
- Reset deasserted mid-stream: the first capture is on the first rising edge with rst high.

## Configuration
- RISCV_V_PIPE_PERF_EN defined:
  - perf_retired_cnt increments on every cycle with wb_valid.
  - perf_stall_cnt increments on every cycle with stall.
  - Both counters wrap modulo 2^32.
- Not defined: both counter ports are tied to 0 and no counter flops are built. Pipeline behaviour is identical either way.

## Structure
- riscv_v_pkg holds:
  - RISCV_V_DATA_WIDTH and RISCV_V_NUM_BYTES_DATA.
  - The packed typedef riscv_v_pipe_payload_t {data, byte_en, wr_addr, is_v2i, int_data}.
- One sub-module, riscv_v_pipe_stage_reg, holds the valid bit and payload flop with hold and kill inputs. It is instantiated twice (MEM, WB). Stall and ready logic live in the top module.

## Test plan
- Reset with rst=0 for 3 cycles, then release → all outputs 0 and ready_exe=1 both during reset and after release.
- Vector op: alu_result data 0x00112233..FF, byte_en 0x00FF, addr 5 → rf_wr_en_mem=0x00FF/addr 5 at +1 cycle; rf_wr_en_wb=0x00FF/data match at +2.
- v2i op with int_data 0xDEADBEEF and int_result_ready low for 3 cycles:
  - int_result_valid held for 4 cycles.
  - ready_exe=0 for 3 cycles.
  - WB shows 3 bubbles.
  - rf_wr_en_wb stays 0 throughout.
- Flush during a pending v2i plus a new valid_exe → int_result_valid drops next cycle; neither op reaches WB or increments the retired counter.
- Back-to-back vector ops to addrs 1,2,3 with valid_exe held high → one write per cycle in WB, in order, with no bubbles.
- With RISCV_V_PIPE_PERF_EN, 10 ops and 4 stall cycles → perf_retired_cnt=10 and perf_stall_cnt=4. Without the macro both read 0.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared widths and pipeline payload type for the vector post-execute pipeline.
// Optional perf counters in the top are enabled by RISCV_V_PIPE_PERF_EN.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH     = 128;
  localparam int RISCV_V_NUM_BYTES_DATA = RISCV_V_DATA_WIDTH / 8;
  localparam int RISCV_V_INT_WIDTH      = 32;

  typedef struct packed {
    logic [RISCV_V_DATA_WIDTH-1:0]     data;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] byte_en;
    logic [4:0]                        wr_addr;
    logic                              is_v2i;
    logic [RISCV_V_INT_WIDTH-1:0]      int_data;
  } riscv_v_pipe_payload_t;

endpackage

// File: rtl/riscv_v_pipe_stage_reg.sv
// One pipeline stage register: a valid bit plus payload, with hold (stall) and kill (flush).
// Kill beats hold, so a flushed stage becomes a bubble even while stalled.
module riscv_v_pipe_stage_reg
  import riscv_v_pkg::*;
#(
  parameter type payload_t = riscv_v_pipe_payload_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  input  logic     kill,
  input  logic     valid_in,
  input  payload_t payload_in,
  output logic     valid,
  output payload_t payload
);

  // NOTE: the payload is reset too, not only the valid bit, because every output
  // of the pipe must read 0 while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
      valid <= valid_in;
      if (valid_in) payload <= payload_in;
    end
  end

endmodule

// File: rtl/riscv_v_mem_wb_pipe.sv
// MEM/WB pipeline for the vector unit: bypass outputs, RF write port and v2i hand-off.
// Define RISCV_V_PIPE_PERF_EN to build the retired/stall performance counters.
module riscv_v_mem_wb_pipe
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int NUM_BYTES  = DATA_WIDTH / 8,
  parameter int INT_WIDTH  = RISCV_V_INT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_exe,
  output logic                            ready_exe,
  input  logic [DATA_WIDTH+NUM_BYTES-1:0] alu_result_exe,
  input  logic [4:0]                      rf_wr_addr_exe,
  input  logic                            is_v2i_exe,
  input  logic [INT_WIDTH-1:0]            int_data_result_exe,
  input  logic                            flush,
  output logic [NUM_BYTES-1:0]            rf_wr_en_mem,
  output logic [4:0]                      rf_wr_addr_mem,
  output logic [DATA_WIDTH-1:0]           rf_wr_data_mem,
  output logic [NUM_BYTES-1:0]            rf_wr_en_wb,
  output logic [4:0]                      rf_wr_addr_wb,
  output logic [DATA_WIDTH-1:0]           rf_wr_data_wb,
  output logic                            int_result_valid,
  output logic [INT_WIDTH-1:0]            int_result_data,
  input  logic                            int_result_ready,
  output logic [31:0]                     perf_retired_cnt,
  output logic [31:0]                     perf_stall_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_BYTES-1:0]  byte_en;
    logic [4:0]            wr_addr;
    logic                  is_v2i;
    logic [INT_WIDTH-1:0]  int_data;
  } mem_payload_t;

  // WB only needs the vector write fields; the scalar result has left at MEM.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_BYTES-1:0]  byte_en;
    logic [4:0]            wr_addr;
  } wb_payload_t;

  logic         mem_valid;
  logic         wb_valid;
  logic         stall;
  mem_payload_t exe_payload;
  mem_payload_t mem_payload;
  wb_payload_t  wb_in;
  wb_payload_t  wb_payload;

  // v2i ops never write a vector register, so their byte enables are dropped at capture.
  assign exe_payload = '{
    data:     alu_result_exe[DATA_WIDTH+NUM_BYTES-1:NUM_BYTES],
    byte_en:  is_v2i_exe ? {NUM_BYTES{1'b0}} : alu_result_exe[NUM_BYTES-1:0],
    wr_addr:  rf_wr_addr_exe,
    is_v2i:   is_v2i_exe,
    int_data: int_data_result_exe
  };

  assign stall     = mem_valid & mem_payload.is_v2i & ~int_result_ready;
  assign ready_exe = ~stall;

  riscv_v_pipe_stage_reg #(.payload_t(mem_payload_t)) u_mem_stage (
    .clk        (clk),
    .rst        (rst),
    .hold       (stall),
    .kill       (flush),
    .valid_in   (valid_exe),
    .payload_in (exe_payload),
    .valid      (mem_valid),
    .payload    (mem_payload)
  );

  assign wb_in = '{
    data:    mem_payload.data,
    byte_en: mem_payload.byte_en,
    wr_addr: mem_payload.wr_addr
  };

  // WB itself is never flushed, but a flush kills the MEM op before it can move on.
  riscv_v_pipe_stage_reg #(.payload_t(wb_payload_t)) u_wb_stage (
    .clk        (clk),
    .rst        (rst),
    .hold       (1'b0),
    .kill       (1'b0),
    .valid_in   (mem_valid & ~stall & ~flush),
    .payload_in (wb_in),
    .valid      (wb_valid),
    .payload    (wb_payload)
  );

  assign rf_wr_en_mem     = mem_valid ? mem_payload.byte_en : '0;
  assign rf_wr_addr_mem   = mem_payload.wr_addr;
  assign rf_wr_data_mem   = mem_payload.data;
  assign rf_wr_en_wb      = wb_valid ? wb_payload.byte_en : '0;
  assign rf_wr_addr_wb    = wb_payload.wr_addr;
  assign rf_wr_data_wb    = wb_payload.data;
  assign int_result_valid = mem_valid & mem_payload.is_v2i;
  assign int_result_data  = mem_payload.int_data;

`ifdef RISCV_V_PIPE_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (wb_valid) retired_q <= retired_q + 32'd1;
      if (stall)    stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_retired_cnt = retired_q;
  assign perf_stall_cnt   = stall_q;
`else
  assign perf_retired_cnt = '0;
  assign perf_stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_riscv_v_mem_wb_pipe.sv
// Self-checking bench for riscv_v_mem_wb_pipe: directed scenarios plus random traffic
// compared every cycle against a slot-level behavioural model.
module tb_riscv_v_mem_wb_pipe;

  logic         clk;
  logic         rst;
  logic         valid_exe;
  logic         ready_exe;
  logic [143:0] alu_result_exe;
  logic [4:0]   rf_wr_addr_exe;
  logic         is_v2i_exe;
  logic [31:0]  int_data_result_exe;
  logic         flush;
  logic [15:0]  rf_wr_en_mem;
  logic [4:0]   rf_wr_addr_mem;
  logic [127:0] rf_wr_data_mem;
  logic [15:0]  rf_wr_en_wb;
  logic [4:0]   rf_wr_addr_wb;
  logic [127:0] rf_wr_data_wb;
  logic         int_result_valid;
  logic [31:0]  int_result_data;
  logic         int_result_ready;
  logic [31:0]  perf_retired_cnt;
  logic [31:0]  perf_stall_cnt;

  riscv_v_mem_wb_pipe dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_exe           (valid_exe),
    .ready_exe           (ready_exe),
    .alu_result_exe      (alu_result_exe),
    .rf_wr_addr_exe      (rf_wr_addr_exe),
    .is_v2i_exe          (is_v2i_exe),
    .int_data_result_exe (int_data_result_exe),
    .flush               (flush),
    .rf_wr_en_mem        (rf_wr_en_mem),
    .rf_wr_addr_mem      (rf_wr_addr_mem),
    .rf_wr_data_mem      (rf_wr_data_mem),
    .rf_wr_en_wb         (rf_wr_en_wb),
    .rf_wr_addr_wb       (rf_wr_addr_wb),
    .rf_wr_data_wb       (rf_wr_data_wb),
    .int_result_valid    (int_result_valid),
    .int_result_data     (int_result_data),
    .int_result_ready    (int_result_ready),
    .perf_retired_cnt    (perf_retired_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rst;
    bit           v;
    bit           v2i;
    bit           fl;
    bit           rdy;
    logic [127:0] d;
    logic [15:0]  be;
    logic [4:0]   a;
    logic [31:0]  id;
  } stim_t;

  // One model slot per architectural stage: what op (if any) sits there.
  typedef struct {
    bit           v;
    logic [127:0] d;
    logic [15:0]  be;
    logic [4:0]   a;
    bit           v2i;
    logic [31:0]  id;
  } slot_t;

  slot_t       m_mem, m_wb;
  int unsigned m_ret, m_stl;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          s_irv, s_rdy;
  logic [15:0] s_wb_en;

  localparam logic [127:0] VEC_DATA = 128'h00112233445566778899AABBCCDDEEFF;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s     = '{default: 0};
    s.rst = 1'b1;
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t vec_op(input logic [127:0] d, input logic [15:0] be, input logic [4:0] a);
    stim_t s;
    s    = idle();
    s.v  = 1'b1;
    s.d  = d;
    s.be = be;
    s.a  = a;
    return s;
  endfunction

  function automatic stim_t v2i_op(input logic [31:0] id);
    stim_t s;
    s     = idle();
    s.v   = 1'b1;
    s.v2i = 1'b1;
    s.id  = id;
    s.be  = 16'hFFFF;
    s.d   = {4{id}};
    s.a   = 5'd31;
    return s;
  endfunction

  function automatic void clear_model();
    m_mem = '{default: 0};
    m_wb  = '{default: 0};
    m_ret = 0;
    m_stl = 0;
  endfunction

  // The single compare point: every output against the model, every cycle.
  task automatic compare_model();
    bit stall_e;
    stall_e = m_mem.v && m_mem.v2i && !int_result_ready;
    check("ready_exe", ready_exe, !stall_e);
    check("rf_wr_en_mem", rf_wr_en_mem, m_mem.v ? m_mem.be : 16'h0);
    if (m_mem.v && m_mem.be != 0) begin
      check("rf_wr_addr_mem", rf_wr_addr_mem, m_mem.a);
      check("rf_wr_data_mem", rf_wr_data_mem, m_mem.d);
    end
    check("rf_wr_en_wb", rf_wr_en_wb, m_wb.v ? m_wb.be : 16'h0);
    if (m_wb.v && m_wb.be != 0) begin
      check("rf_wr_addr_wb", rf_wr_addr_wb, m_wb.a);
      check("rf_wr_data_wb", rf_wr_data_wb, m_wb.d);
    end
    check("int_result_valid", int_result_valid, m_mem.v && m_mem.v2i);
    if (m_mem.v && m_mem.v2i) check("int_result_data", int_result_data, m_mem.id);
`ifdef RISCV_V_PIPE_PERF_EN
    check("perf_retired_cnt", perf_retired_cnt, m_ret);
    check("perf_stall_cnt", perf_stall_cnt, m_stl);
`else
    check("perf_retired_cnt", perf_retired_cnt, 32'd0);
    check("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
  endtask

  // Drive one cycle of stimulus, compare, then advance the model across the edge.
  task automatic cycle(input stim_t s);
    slot_t       n_mem, n_wb;
    int unsigned n_ret, n_stl;
    bit          stall_e;
    @(negedge clk);
    rst                 = s.rst;
    valid_exe           = s.v;
    is_v2i_exe          = s.v2i;
    flush               = s.fl;
    int_result_ready    = s.rdy;
    alu_result_exe      = {s.d, s.be};
    rf_wr_addr_exe      = s.a;
    int_data_result_exe = s.id;
    if (!s.rst) clear_model();
    #1;
    compare_model();
    s_irv   = int_result_valid;
    s_rdy   = ready_exe;
    s_wb_en = rf_wr_en_wb;
    stall_e = m_mem.v && m_mem.v2i && !s.rdy;
    n_mem   = m_mem;
    n_wb    = m_mem;
    n_wb.v  = m_mem.v && !stall_e && !s.fl;
    if (s.fl) n_mem.v = 1'b0;
    else if (!stall_e) n_mem = '{v: s.v, d: s.d, be: s.v2i ? 16'h0 : s.be, a: s.a, v2i: s.v2i, id: s.id};
    n_ret = m_ret + (m_wb.v ? 1 : 0);
    n_stl = m_stl + (stall_e ? 1 : 0);
    @(posedge clk);
    if (s.rst) begin
      m_mem = n_mem;
      m_wb  = n_wb;
      m_ret = n_ret;
      m_stl = n_stl;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t       s;
    int          cnt_irv, cnt_nrdy;
    logic [15:0] wb_or;

    rst = 1'b0; valid_exe = 1'b0; is_v2i_exe = 1'b0; flush = 1'b0;
    int_result_ready = 1'b1; alu_result_exe = '0; rf_wr_addr_exe = '0;
    int_data_result_exe = '0;
    clear_model();

    // Reset held three cycles, then released.
    s = idle();
    s.rst = 1'b0;
    s.v   = 1'b1;
    s.d   = VEC_DATA;
    s.be  = 16'hFFFF;
    repeat (3) begin
      cycle(s);
      #1;
      check("lit_reset_ready", ready_exe, 1'b1);
      check("lit_reset_wb_en", rf_wr_en_wb, 16'h0);
      check("lit_reset_mem_data", rf_wr_data_mem, 128'h0);
    end
    cycle(idle());
    #1;
    check("lit_release_ready", ready_exe, 1'b1);
    check("lit_release_mem_en", rf_wr_en_mem, 16'h0);
    check("lit_release_irv", int_result_valid, 1'b0);

    // Single vector op: MEM bypass after 1 edge, RF write after 2.
    cycle(vec_op(VEC_DATA, 16'h00FF, 5'd5));
    #1;
    check("lit_vec_mem_en", rf_wr_en_mem, 16'h00FF);
    check("lit_vec_mem_addr", rf_wr_addr_mem, 5'd5);
    cycle(idle());
    #1;
    check("lit_vec_wb_en", rf_wr_en_wb, 16'h00FF);
    check("lit_vec_wb_addr", rf_wr_addr_wb, 5'd5);
    check("lit_vec_wb_data", rf_wr_data_wb, VEC_DATA);

    // v2i with the scalar core not ready for three cycles.
    s = v2i_op(32'hDEADBEEF);
    s.rdy = 1'b0;
    cycle(s);
    #1;
    check("lit_v2i_data", int_result_data, 32'hDEADBEEF);
    cnt_irv = 0; cnt_nrdy = 0; wb_or = '0;
    for (int i = 0; i < 4; i++) begin
      s = vec_op(VEC_DATA, 16'hFFFF, 5'd9);
      s.rdy = (i == 3);
      cycle(s);
      cnt_irv  += s_irv ? 1 : 0;
      cnt_nrdy += s_rdy ? 0 : 1;
      wb_or    |= s_wb_en;
    end
    #1;
    check("lit_v2i_valid_cycles", cnt_irv, 4);
    check("lit_v2i_notready_cycles", cnt_nrdy, 3);
    check("lit_v2i_wb_bubbles", wb_or, 16'h0);
    check("lit_v2i_wb_en_after", rf_wr_en_wb, 16'h0);
    check("lit_v2i_next_mem_addr", rf_wr_addr_mem, 5'd9);

    // Flush with a pending v2i and a new op offered.
    cycle(idle());
    cycle(idle());
    s = v2i_op(32'h12345678);
    s.rdy = 1'b0;
    cycle(s);
    s = vec_op(VEC_DATA, 16'hFFFF, 5'd12);
    s.fl  = 1'b1;
    s.rdy = 1'b0;
    cycle(s);
    #1;
    check("lit_flush_irv", int_result_valid, 1'b0);
    check("lit_flush_mem_en", rf_wr_en_mem, 16'h0);
    repeat (2) begin
      cycle(idle());
      #1;
      check("lit_flush_wb_en", rf_wr_en_wb, 16'h0);
    end

    // Back-to-back vector ops to addresses 1, 2, 3.
    cycle(vec_op(128'h1, 16'hFFFF, 5'd1));
    cycle(vec_op(128'h2, 16'hFFFF, 5'd2));
    #1;
    check("lit_b2b_wb_addr1", rf_wr_addr_wb, 5'd1);
    cycle(vec_op(128'h3, 16'hFFFF, 5'd3));
    #1;
    check("lit_b2b_wb_addr2", rf_wr_addr_wb, 5'd2);
    check("lit_b2b_wb_en2", rf_wr_en_wb, 16'hFFFF);
    cycle(idle());
    #1;
    check("lit_b2b_wb_addr3", rf_wr_addr_wb, 5'd3);
    check("lit_b2b_wb_data3", rf_wr_data_wb, 128'h3);
    cycle(idle());
    #1;
    check("lit_b2b_drained", rf_wr_en_wb, 16'h0);

    // Counters: 10 ops with 4 stall cycles, from a fresh reset.
    s = idle();
    s.rst = 1'b0;
    cycle(s);
    s = v2i_op(32'hCAFEF00D);
    s.rdy = 1'b0;
    cycle(s);
    s = idle();
    s.rdy = 1'b0;
    repeat (4) cycle(s);
    for (int i = 0; i < 9; i++) cycle(vec_op({4{$urandom}}, 16'hF0F0, 5'(i)));
    repeat (3) cycle(idle());
    #1;
`ifdef RISCV_V_PIPE_PERF_EN
    check("lit_perf_retired", perf_retired_cnt, 32'd10);
    check("lit_perf_stall", perf_stall_cnt, 32'd4);
`else
    check("lit_perf_retired_off", perf_retired_cnt, 32'd0);
    check("lit_perf_stall_off", perf_stall_cnt, 32'd0);
`endif

    // Random traffic, including occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      s     = idle();
      s.rst = ($urandom_range(99) != 0);
      s.v   = ($urandom_range(9) < 7);
      s.v2i = ($urandom_range(3) == 0);
      s.fl  = ($urandom_range(19) == 0);
      s.rdy = ($urandom_range(9) < 6);
      s.d   = {$urandom, $urandom, $urandom, $urandom};
      s.be  = 16'($urandom);
      s.a   = 5'($urandom);
      s.id  = $urandom;
      cycle(s);
    end
    cycle(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
